// File: rtl/solver_stage_sequencer.sv
// rtl/solver_stage_sequencer.sv - fixed-order reset/start/end sequencer for solver stage controllers
// Optional watchdog: define SOLVER_STAGE_WATCHDOG_EN.
module solver_stage_sequencer #(
    parameter int NUM_STAGES     = 5,
    parameter int STAGE_W        = 3,
    parameter int CYC_W          = 24,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TMO_W          = 16
) (
    input  logic                  clk,
    input  logic                  program_reset,
    input  logic                  run,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_mask,
    input  logic [NUM_STAGES-1:0] end_process,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic [NUM_STAGES-1:0] start_process,
    output logic [STAGE_W-1:0]    current_stage,
    output logic                  busy,
    output logic                  all_done,
    output logic [CYC_W-1:0]      total_cycles,
    output logic                  error,
    output logic [STAGE_W-1:0]    error_stage
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_RESET_STAGE,
        S_RUN_STAGE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [STAGE_W-1:0]    stage_q, stage_d;
    logic [CYC_W-1:0]      cyc_q;
    logic                  clear_cyc;
    logic                  timeout;
    logic [NUM_STAGES-1:0] stage_onehot;
    logic                  cur_enabled;
    logic                  cur_end;

    // Zero once current_stage has walked past the last stage, so mask/end lookups never go out of range.
    assign stage_onehot = NUM_STAGES'(1) << stage_q;
    assign cur_enabled  = |(stage_mask & stage_onehot);
    assign cur_end      = |(end_process & stage_onehot);

`ifdef SOLVER_STAGE_WATCHDOG_EN
    logic [TMO_W-1:0]   wdog_q;
    logic [STAGE_W-1:0] err_stage_q;

    assign timeout     = (wdog_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign error       = (state_q == S_ERROR);
    assign error_stage = err_stage_q;

    always_ff @(posedge clk) begin
        if (program_reset) begin
            wdog_q      <= '0;
            err_stage_q <= '0;
        end else begin
            if (state_q == S_RESET_STAGE)
                wdog_q <= '0;
            else if (state_q == S_RUN_STAGE)
                wdog_q <= wdog_q + TMO_W'(1);
            if (state_q == S_RUN_STAGE && state_d == S_ERROR)
                err_stage_q <= stage_q;
        end
    end
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = ^{TIMEOUT_CYCLES, TMO_W};
    assign timeout         = 1'b0;
    assign error           = 1'b0;
    assign error_stage     = '0;
`endif

    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        stage_reset   = '0;
        start_process = '0;
        clear_cyc     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (run) begin
                    state_d   = S_SELECT;
                    stage_d   = '0;
                    clear_cyc = 1'b1;
                end
            end
            S_SELECT: begin
                if (abort)
                    state_d = S_IDLE;
                else if (stage_q == STAGE_W'(NUM_STAGES))
                    state_d = S_DONE;
                else if (!cur_enabled)
                    stage_d = stage_q + STAGE_W'(1);
                else
                    state_d = S_RESET_STAGE;
            end
            S_RESET_STAGE: begin
                stage_reset = stage_onehot;
                state_d     = abort ? S_IDLE : S_RUN_STAGE;
            end
            S_RUN_STAGE: begin
                start_process = stage_onehot;
                // Abort beats completion, and completion beats a coincident timeout.
                if (abort) begin
                    state_d     = S_IDLE;
                    stage_reset = stage_onehot;
                end else if (cur_end) begin
                    state_d = S_SELECT;
                    stage_d = stage_q + STAGE_W'(1);
                end else if (timeout) begin
                    state_d     = S_ERROR;
                    stage_reset = stage_onehot;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (program_reset) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            if (clear_cyc)
                cyc_q <= '0;
            else if (busy && !(&cyc_q))
                cyc_q <= cyc_q + CYC_W'(1);
        end
    end

    assign busy          = (state_q == S_SELECT) || (state_q == S_RESET_STAGE) || (state_q == S_RUN_STAGE);
    assign all_done      = (state_q == S_DONE);
    assign current_stage = stage_q;
    assign total_cycles  = cyc_q;

endmodule

// File: tb/tb_solver_stage_sequencer.sv
// tb/tb_solver_stage_sequencer.sv - directed self-checking bench for solver_stage_sequencer
module tb_solver_stage_sequencer;

    logic        clk = 1'b0;
    logic        program_reset = 1'b1;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  stage_mask = 5'b11111;
    logic [4:0]  end_process;
    logic [4:0]  stage_reset;
    logic [4:0]  start_process;
    logic [2:0]  current_stage;
    logic        busy;
    logic        all_done;
    logic [23:0] total_cycles;
    logic        error;
    logic [2:0]  error_stage;

    int tests = 0;
    int fails = 0;

    int         lat [5] = '{default: 0};
    int         cnt [5] = '{default: 0};
    logic [4:0] model_end;
    logic [4:0] end_force = 5'b0;

    int         rst_cnt [5] = '{default: 0};
    int         start_cnt [5] = '{default: 0};
    int         onehot_err = 0;
    int         order [$];
    logic [4:0] prev_start = 5'b0;

    always #5 clk = ~clk;

    solver_stage_sequencer #(
        .NUM_STAGES(5), .STAGE_W(3), .CYC_W(24), .TIMEOUT_CYCLES(10), .TMO_W(16)
    ) dut (
        .clk(clk), .program_reset(program_reset), .run(run), .abort(abort),
        .stage_mask(stage_mask), .end_process(end_process), .stage_reset(stage_reset),
        .start_process(start_process), .current_stage(current_stage), .busy(busy),
        .all_done(all_done), .total_cycles(total_cycles), .error(error), .error_stage(error_stage)
    );

    // Stage controller model: counts start cycles, holds done until its stage_reset.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (program_reset || stage_reset[i])
                cnt[i] <= 0;
            else if (start_process[i])
                cnt[i] <= cnt[i] + 1;
        end
    end

    always_comb begin
        model_end = 5'b0;
        for (int i = 0; i < 5; i++)
            model_end[i] = (cnt[i] >= lat[i]);
    end

    assign end_process = model_end | end_force;

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (stage_reset[i]) rst_cnt[i]++;
            if (start_process[i]) start_cnt[i]++;
            if (start_process[i] && !prev_start[i]) order.push_back(i);
        end
        if ((start_process & (start_process - 5'd1)) != 5'b0) onehot_err++;
        prev_start = start_process;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 5; i++) begin
            rst_cnt[i]   = 0;
            start_cnt[i] = 0;
        end
        onehot_err = 0;
        order.delete();
    endtask

    task automatic run_until_done(input int max, output int n);
        n = 0;
        while (!all_done && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        program_reset = 1'b1;
        step();
        step();
        tests++;
        if ({busy, all_done, error, current_stage, error_stage, stage_reset, start_process, total_cycles} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b stage=%0d est=%0d rst=%b start=%b cyc=%0d, required all 0",
                     busy, all_done, error, current_stage, error_stage, stage_reset, start_process, total_cycles);
        end
        program_reset = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_full_run();
        int n;
        int bad;
        stage_mask = 5'b11111;
        for (int i = 0; i < 5; i++) lat[i] = 4;
        clear_mon();
        pulse_run();
        tests++;
        if (busy !== 1'b1 || current_stage !== 3'd0 || total_cycles !== 24'd0) begin
            fails++;
            $display("FAIL full_start: busy=%0b stage=%0d cyc=%0d, required 1 0 0", busy, current_stage, total_cycles);
        end
        run_until_done(200, n);
        tests++;
        if (all_done !== 1'b1 || n !== 36) begin
            fails++;
            $display("FAIL full_latency: done=%0b cycles=%0d, required 1 36", all_done, n);
        end
        tests++;
        if (total_cycles !== 24'd36 || current_stage !== 3'd5 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full_totals: cyc=%0d stage=%0d busy=%0b, required 36 5 0", total_cycles, current_stage, busy);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) if (rst_cnt[i] != 1 || start_cnt[i] != 5) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL full_per_stage: %0d stages with wrong reset/start counts, required 0", bad);
        end
        bad = (order.size() == 5) ? 0 : 1;
        for (int i = 0; i < order.size() && i < 5; i++) if (order[i] != i) bad++;
        tests++;
        if (bad !== 0 || onehot_err !== 0) begin
            fails++;
            $display("FAIL full_order: order_errors=%0d onehot_errors=%0d, required 0 0", bad, onehot_err);
        end
        step();
        step();
        tests++;
        if (all_done !== 1'b1 || current_stage !== 3'd5) begin
            fails++;
            $display("FAIL done_hold: done=%0b stage=%0d, required 1 5", all_done, current_stage);
        end
    endtask

    task automatic test_mask();
        int n;
        stage_mask = 5'b10101;
        for (int i = 0; i < 5; i++) lat[i] = 2;
        clear_mon();
        pulse_run();
        run_until_done(200, n);
        tests++;
        if (all_done !== 1'b1 || total_cycles !== 24'd18) begin
            fails++;
            $display("FAIL mask_total: done=%0b cyc=%0d, required 1 18", all_done, total_cycles);
        end
        tests++;
        if (rst_cnt[1] != 0 || rst_cnt[3] != 0 || start_cnt[1] != 0 || start_cnt[3] != 0 ||
            rst_cnt[0] != 1 || rst_cnt[2] != 1 || rst_cnt[4] != 1) begin
            fails++;
            $display("FAIL mask_skip: rst=%0d,%0d,%0d,%0d,%0d start1=%0d start3=%0d, required 1,0,1,0,1 0 0",
                     rst_cnt[0], rst_cnt[1], rst_cnt[2], rst_cnt[3], rst_cnt[4], start_cnt[1], start_cnt[3]);
        end
        stage_mask = 5'b00000;
        clear_mon();
        pulse_run();
        run_until_done(50, n);
        tests++;
        if (all_done !== 1'b1 || n !== 6 || total_cycles !== 24'd6) begin
            fails++;
            $display("FAIL mask_empty: done=%0b cycles=%0d cyc=%0d, required 1 6 6", all_done, n, total_cycles);
        end
        tests++;
        if ((rst_cnt[0] + rst_cnt[1] + rst_cnt[2] + rst_cnt[3] + rst_cnt[4] +
             start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3] + start_cnt[4]) != 0) begin
            fails++;
            $display("FAIL mask_empty_quiet: stage activity seen with empty mask, required none");
        end
    endtask

    task automatic test_abort();
        int k;
        stage_mask = 5'b11111;
        lat[0] = 0; lat[1] = 0; lat[2] = 100; lat[3] = 0; lat[4] = 0;
        clear_mon();
        pulse_run();
        k = 0;
        while (!start_process[2] && k < 50) begin
            step();
            k++;
        end
        tests++;
        if (start_process !== 5'b00100 || current_stage !== 3'd2) begin
            fails++;
            $display("FAIL abort_reach: start=%b stage=%0d, required 00100 2", start_process, current_stage);
        end
        pulse_run();
        tests++;
        if (start_process !== 5'b00100 || current_stage !== 3'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL run_while_busy: start=%b stage=%0d busy=%0b, required 00100 2 1", start_process, current_stage, busy);
        end
        end_force = 5'b10100;
        abort = 1'b1;
        #1;
        tests++;
        if (stage_reset !== 5'b00100) begin
            fails++;
            $display("FAIL abort_pulse: stage_reset=%b, required 00100", stage_reset);
        end
        step();
        abort = 1'b0;
        end_force = 5'b0;
        step();
        step();
        tests++;
        if (busy !== 1'b0 || all_done !== 1'b0 || start_process !== 5'b0 || stage_reset !== 5'b0) begin
            fails++;
            $display("FAIL abort_idle: busy=%0b done=%0b start=%b rst=%b, required 0 0 0 0", busy, all_done, start_process, stage_reset);
        end
        tests++;
        if (rst_cnt[2] != 2 || rst_cnt[3] != 0 || rst_cnt[4] != 0) begin
            fails++;
            $display("FAIL abort_counts: rst2=%0d rst3=%0d rst4=%0d, required 2 0 0", rst_cnt[2], rst_cnt[3], rst_cnt[4]);
        end
    endtask

    task automatic test_prog_reset();
        int k;
        int n;
        stage_mask = 5'b11111;
        for (int i = 0; i < 5; i++) lat[i] = 1;
        pulse_run();
        k = 0;
        while (!start_process[3] && k < 50) begin
            step();
            k++;
        end
        tests++;
        if (start_process !== 5'b01000) begin
            fails++;
            $display("FAIL preset_reach: start=%b, required 01000", start_process);
        end
        program_reset = 1'b1;
        run = 1'b1;
        abort = 1'b1;
        step();
        program_reset = 1'b0;
        run = 1'b0;
        abort = 1'b0;
        tests++;
        if ({busy, all_done, error, current_stage, error_stage, stage_reset, start_process, total_cycles} !== '0) begin
            fails++;
            $display("FAIL preset_outputs: busy=%0b done=%0b stage=%0d rst=%b start=%b cyc=%0d, required all 0",
                     busy, all_done, current_stage, stage_reset, start_process, total_cycles);
        end
        clear_mon();
        pulse_run();
        step();
        tests++;
        if (stage_reset !== 5'b00001 || current_stage !== 3'd0) begin
            fails++;
            $display("FAIL preset_restart: rst=%b stage=%0d, required 00001 0", stage_reset, current_stage);
        end
        run_until_done(200, n);
        tests++;
        if (all_done !== 1'b1 || total_cycles !== 24'd21) begin
            fails++;
            $display("FAIL preset_rerun: done=%0b cyc=%0d, required 1 21", all_done, total_cycles);
        end
    endtask

    task automatic test_watchdog();
        int k;
        int n;
        stage_mask = 5'b11111;
        lat[0] = 0; lat[1] = 200; lat[2] = 0; lat[3] = 0; lat[4] = 0;
        clear_mon();
        pulse_run();
`ifdef SOLVER_STAGE_WATCHDOG_EN
        k = 0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        tests++;
        if (error !== 1'b1 || error_stage !== 3'd1 || all_done !== 1'b0) begin
            fails++;
            $display("FAIL wdog_fire: err=%0b est=%0d done=%0b, required 1 1 0", error, error_stage, all_done);
        end
        tests++;
        if (start_cnt[1] != 10 || rst_cnt[1] != 2 || rst_cnt[2] != 0) begin
            fails++;
            $display("FAIL wdog_counts: run1=%0d rst1=%0d rst2=%0d, required 10 2 0", start_cnt[1], rst_cnt[1], rst_cnt[2]);
        end
        lat[1] = 0;
        pulse_run();
        tests++;
        if (error !== 1'b0 || current_stage !== 3'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL wdog_restart: err=%0b stage=%0d busy=%0b, required 0 0 1", error, current_stage, busy);
        end
        run_until_done(200, n);
        tests++;
        if (all_done !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL wdog_rerun: done=%0b err=%0b, required 1 0", all_done, error);
        end
`else
        for (k = 0; k < 40; k++) step();
        tests++;
        if (error !== 1'b0 || error_stage !== 3'd0 || busy !== 1'b1 || current_stage !== 3'd1) begin
            fails++;
            $display("FAIL no_wdog_hang: err=%0b est=%0d busy=%0b stage=%0d, required 0 0 1 1", error, error_stage, busy, current_stage);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || rst_cnt[1] != 2) begin
            fails++;
            $display("FAIL no_wdog_abort: busy=%0b rst1=%0d, required 0 2", busy, rst_cnt[1]);
        end
`endif
    endtask

    task automatic test_timeout_edge();
        int n;
        stage_mask = 5'b11111;
        lat[0] = 9; lat[1] = 0; lat[2] = 0; lat[3] = 0; lat[4] = 0;
        clear_mon();
        pulse_run();
        run_until_done(200, n);
        tests++;
        if (all_done !== 1'b1 || error !== 1'b0 || total_cycles !== 24'd25) begin
            fails++;
            $display("FAIL edge_complete: done=%0b err=%0b cyc=%0d, required 1 0 25", all_done, error, total_cycles);
        end
        tests++;
        if (start_cnt[0] != 10 || rst_cnt[0] != 1 || rst_cnt[1] != 1) begin
            fails++;
            $display("FAIL edge_counts: run0=%0d rst0=%0d rst1=%0d, required 10 1 1", start_cnt[0], rst_cnt[0], rst_cnt[1]);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_mask();
        test_abort();
        test_prog_reset();
        test_watchdog();
        test_timeout_edge();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
